// File: rtl/clock_calendar_if.sv
// Control inputs and displayed fields of the clock/calendar core.
// The master side (button logic / bench) drives the inputs; the core is the slave.
interface clock_calendar_if #(
  parameter int unsigned YEAR_W = 12
);
  logic              tick_en;
  logic              mode_btn;
  logic              set_btn;
  logic              inc_btn;
  logic [4:0]        hh;
  logic [5:0]        mm;
  logic [5:0]        ss;
  logic [YEAR_W-1:0] year;
  logic [3:0]        mon;
  logic [4:0]        day;
  logic              mode;
  logic [2:0]        edit_field;
  logic              sec_pulse;

  modport master (
    output tick_en, mode_btn, set_btn, inc_btn,
    input  hh, mm, ss, year, mon, day, mode, edit_field, sec_pulse
  );

  modport slave (
    input  tick_en, mode_btn, set_btn, inc_btn,
    output hh, mm, ss, year, mon, day, mode, edit_field, sec_pulse
  );
endinterface

// File: rtl/clock_calendar.sv
// Time-of-day and Gregorian calendar core with a button-driven edit FSM.
// Seconds come from TICKS_PER_SEC qualified clk18 cycles; all carries settle on one edge.
module clock_calendar #(
  parameter int unsigned TICKS_PER_SEC = 18,
  parameter int unsigned YEAR_W        = 12,
  parameter int unsigned YEAR_INIT     = 2022,
  parameter int unsigned MON_INIT      = 11,
  parameter int unsigned DAY_INIT      = 24
) (
  input  logic            clk18,
  input  logic            rst,
  clock_calendar_if.slave cal
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  // Encoding doubles as the edit_field code.
  typedef enum logic [2:0] {
    RUN  = 3'd0,
    E_HH = 3'd1,
    E_MM = 3'd2,
    E_YR = 3'd3,
    E_MO = 3'd4,
    E_DY = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        hh_q, hh_d;
  logic [5:0]        mm_q, mm_d;
  logic [5:0]        ss_q, ss_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic [3:0]        mon_q, mon_d;
  logic [4:0]        day_q, day_d;
  logic              mode_q, mode_d;
  logic              sec_pulse_q, sec_pulse_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [4:0]        dim_cur, dim_nxt;

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    logic [31:0] y32;
    logic        leap;
    y32  = 32'(y);
    leap = ((y32 % 32'd4) == 32'd0 && (y32 % 32'd100) != 32'd0) || (y32 % 32'd400) == 32'd0;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      4'd2:                    days_in = leap ? 5'd29 : 5'd28;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  assign dim_cur = days_in(mon_q, year_q);

  always_comb begin
    state_d     = state_q;
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    year_d      = year_q;
    mon_d       = mon_q;
    day_d       = day_q;
    mode_d      = mode_q;
    presc_d     = presc_q;
    sec_pulse_d = 1'b0;
    dim_nxt     = '0;

    unique case (state_q)
      RUN: begin
        // mode toggles before the edit page is chosen; a tick coinciding with set_btn is dropped.
        mode_d = mode_q ^ cal.mode_btn;
        if (cal.set_btn) begin
          state_d = mode_d ? E_YR : E_HH;
          presc_d = '0;
        end else if (cal.tick_en) begin
          if (presc_q == PRESC_MAX) begin
            presc_d     = '0;
            sec_pulse_d = 1'b1;
            if (ss_q == 6'd59) begin
              ss_d = '0;
              if (mm_q == 6'd59) begin
                mm_d = '0;
                if (hh_q == 5'd23) begin
                  hh_d = '0;
                  if (day_q == dim_cur) begin
                    day_d = 5'd1;
                    if (mon_q == 4'd12) begin
                      mon_d  = 4'd1;
                      year_d = year_q + YEAR_W'(1);
                    end else begin
                      mon_d = mon_q + 4'd1;
                    end
                  end else begin
                    day_d = day_q + 5'd1;
                  end
                end else begin
                  hh_d = hh_q + 5'd1;
                end
              end else begin
                mm_d = mm_q + 6'd1;
              end
            end else begin
              ss_d = ss_q + 6'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      E_HH: begin
        if (cal.set_btn) begin
          state_d = E_MM;
          presc_d = '0;
        end else if (cal.inc_btn) begin
          hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end
      end
      E_MM: begin
        if (cal.set_btn) begin
          state_d = RUN;
          ss_d    = '0;
          presc_d = '0;
        end else if (cal.inc_btn) begin
          mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        end
      end
      E_YR: begin
        if (cal.set_btn) begin
          state_d = E_MO;
          presc_d = '0;
        end else if (cal.inc_btn) begin
          year_d = year_q + YEAR_W'(1);
        end
      end
      E_MO: begin
        if (cal.set_btn) begin
          state_d = E_DY;
          presc_d = '0;
        end else if (cal.inc_btn) begin
          mon_d = (mon_q == 4'd12) ? 4'd1 : mon_q + 4'd1;
        end
      end
      E_DY: begin
        if (cal.set_btn) begin
          state_d = RUN;
        end else if (cal.inc_btn) begin
          day_d = (day_q == dim_cur) ? 5'd1 : day_q + 5'd1;
        end
      end
      default: state_d = RUN;
    endcase

    // Clamp against the month/year being written this cycle; a no-op unless they changed.
    dim_nxt = days_in(mon_d, year_d);
    if (day_d > dim_nxt) day_d = dim_nxt;
  end

  always_ff @(posedge clk18 or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      year_q      <= YEAR_W'(YEAR_INIT);
      mon_q       <= 4'(MON_INIT);
      day_q       <= 5'(DAY_INIT);
      mode_q      <= 1'b0;
      sec_pulse_q <= 1'b0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      year_q      <= year_d;
      mon_q       <= mon_d;
      day_q       <= day_d;
      mode_q      <= mode_d;
      sec_pulse_q <= sec_pulse_d;
      presc_q     <= presc_d;
    end
  end

  assign cal.hh         = hh_q;
  assign cal.mm         = mm_q;
  assign cal.ss         = ss_q;
  assign cal.year       = year_q;
  assign cal.mon        = mon_q;
  assign cal.day        = day_q;
  assign cal.mode       = mode_q;
  assign cal.edit_field = state_q;
  assign cal.sec_pulse  = sec_pulse_q;

endmodule

// File: doc/clock_calendar.md
# clock_calendar

Parametrised time-of-day and calendar core for the seven-segment clock display. It counts seconds from a gated tick stream in the clk18 domain and keeps HH:MM:SS plus a real Gregorian date with month lengths and leap years. A button-driven edit state machine lets the user set the time and date fields. Binary field values feed the existing binary-to-LED7 converters; `mode` selects the time or date page for the HEX mux.

## Interface
- TICKS_PER_SEC, 18, clk18 enabled ticks per second; legal range ≥1
- YEAR_W, 12, year register width; year wraps modulo 2^YEAR_W
- YEAR_INIT, 2022, year loaded on reset
- MON_INIT, 11, month loaded on reset (1..12)
- DAY_INIT, 24, day loaded on reset (1..days of MON_INIT)
- clk18  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- tick_en  input  1  qualifies a clk18 cycle as a time tick (chase-LED strobe)
- mode_btn  input  1  one-cycle debounced pulse; toggles the display page
- set_btn  input  1  one-cycle debounced pulse; enters, advances or leaves edit
- inc_btn  input  1  one-cycle debounced pulse; increments the field being edited
- hh  output  5  hours 0..23
- mm  output  6  minutes 0..59
- ss  output  6  seconds 0..59
- year  output  YEAR_W  year
- mon  output  4  month 1..12
- day  output  5  day 1..31
- mode  output  1  0 = time page, 1 = date page
- edit_field  output  3  0 none, 1 hh, 2 mm, 3 year, 4 mon, 5 day
- sec_pulse  output  1  one-cycle strobe after each second advance

## Operation
- FSM states: RUN, E_HH, E_MM, E_YR, E_MO, E_DY. `edit_field` is 0 in RUN and takes the matching code 1..5 in each edit state.
- Entering edit from RUN on set_btn:
  - mode=0 → E_HH.
  - mode=1 → E_YR.
- set_btn advances through the edit states:
  - Time: E_HH→E_MM→RUN.
  - Date: E_YR→E_MO→E_DY→RUN.
- Leaving E_MM clears ss and the prescaler.
- Entering any edit state clears the prescaler.
- mode_btn toggles mode in RUN only. It is ignored in the edit states.
- inc_btn in an edit state increments the selected field with wrap:
  - hh 23→0.
  - mm 59→0.
  - year 2^YEAR_W−1→0.
  - mon 12→1.
  - day dim→1, where dim is the days in the current month/year.
- inc_btn is ignored in RUN.
- Day clamp: after any year or mon change, if day > dim then day := dim in the same cycle.
- dim values:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Feb: 29 if leap, else 28.
  - Leap year: (year%4==0 && year%100!=0) || year%400==0.
- Timekeeping runs only in RUN; every edit state freezes all counters.
- Prescaler counts cycles with tick_en=1 over the range 0..TICKS_PER_SEC−1.
- On the tick_en edge where the prescaler is at TICKS_PER_SEC−1, the prescaler returns to 0 and the seconds cascade fires:
  - ss 59→0 carries to mm.
  - mm 59→0 carries to hh.
  - hh 23→0 carries to day.
  - day==dim→1 carries to mon.
  - mon 12→1 carries to year+1.
- All carries resolve on the same edge, so no illegal value (ss=60, hh=24, day=32) is ever visible.

## Timing
- Reset values: hh=mm=ss=0, year=YEAR_INIT, mon=MON_INIT, day=DAY_INIT, mode=0, edit_field=0, sec_pulse=0, FSM=RUN, prescaler=0.
- Reset asserted mid-edit aborts the edit. Fields revert to their reset values, not to the partially edited ones.
- Field outputs are registered and update on the clk18 edge that samples the tick or button.
- sec_pulse is high during the cycle after a second advance.
- Button response has 1-cycle latency: state and field change on the edge sampling the pulse.
- Simultaneous set_btn and inc_btn: set_btn wins and inc_btn is dropped.
- Simultaneous mode_btn and set_btn in RUN: mode toggles first, and the edit page follows the new mode.
- tick_en=0 holds the prescaler and all fields.
- With TICKS_PER_SEC=1, every tick_en cycle is one second.

## Test plan
- Year rollover: reset, then load 2022-12-31 23:59:59 via edit; exit via E_DY and set ss by running. Apply 18 tick_en cycles → 2023-01-01 00:00:00, with sec_pulse high for exactly 1 cycle.
- Leap years:
  - 2024-02-28 23:59:59 + 1 s → 2024-02-29.
  - 2100-02-28 23:59:59 + 1 s → 2100-03-01.
  - 2000-02-28 23:59:59 + 1 s → 2000-02-29.
- Gating: toggle tick_en at 50% for 72 cycles → ss advances by exactly 2. With tick_en held low for 100 cycles, all outputs are unchanged.
- Time edit: in mode 0, set_btn → edit_field=1. 25 inc_btn → hh=1. Then set_btn, 61 inc_btn → mm=1. Then set_btn → RUN with ss=0 and edit_field=0.
- Day clamp and conflicts:
  - Date 2023-01-31: edit mon to 2 → day=28.
  - set_btn+inc_btn together in E_MO → state E_DY with mon unchanged.
  - mode_btn in E_DY → mode unchanged.
- Reset mid-edit: assert rst in E_HH after 5 inc_btn → hh=0, FSM=RUN, date=2022-11-24 immediately (asynchronous).
